// File: rtl/char_buffer_loader.sv
// Host character-stream loader for a RAM shared with the processor. The RAM port is muxed by the registered state.
// Optional build macro CHAR_BUFFER_CLEAR_EN: zero-fill the buffer before every load.
module char_buffer_loader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 1500,
  parameter int unsigned BUF_DEPTH = 108
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] char_data,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wen,
  output logic [7:0]        char_count,
  output logic              buf_full,
  output logic              overflow
);

  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_EXEC = 2'b10;
  localparam logic [7:0] LAST_IDX  = 8'(BUF_DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

`ifdef CHAR_BUFFER_CLEAR_EN
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_LOAD, ST_FULL, ST_EXEC} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FULL, ST_EXEC} state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       full_q, full_d;
  logic       ovf_q, ovf_d;
`ifdef CHAR_BUFFER_CLEAR_EN
  logic [7:0] clr_q, clr_d;
`endif

  logic              accept;
  logic [ADDR_W-1:0] load_addr;

  assign char_ready = (state_q == ST_LOAD);
  assign accept     = char_valid & char_ready;
  assign load_addr  = BASE + ADDR_W'(count_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
`ifdef CHAR_BUFFER_CLEAR_EN
    clr_d   = clr_q;
`endif
    // An accepted character is written even if mode changes in that cycle, so it is always counted.
    if (accept) begin
      count_d = count_q + 8'd1;
      if (count_q == LAST_IDX) full_d = 1'b1;
    end
    if (state_q == ST_FULL && char_valid) ovf_d = 1'b1;

    case (mode)
      MODE_EXEC: state_d = ST_EXEC;
      MODE_LOAD: begin
        case (state_q)
          ST_IDLE, ST_EXEC: begin
`ifdef CHAR_BUFFER_CLEAR_EN
            state_d = ST_CLEAR;
            clr_d   = '0;
`else
            state_d = ST_LOAD;
`endif
            count_d = '0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
          end
`ifdef CHAR_BUFFER_CLEAR_EN
          ST_CLEAR: begin
            if (clr_q == LAST_IDX) state_d = ST_LOAD;
            else                   clr_d   = clr_q + 8'd1;
          end
`endif
          ST_LOAD: begin
            if (accept && count_q == LAST_IDX) state_d = ST_FULL;
          end
          ST_FULL: state_d = ST_FULL;
          default: state_d = ST_IDLE;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef CHAR_BUFFER_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
`ifdef CHAR_BUFFER_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_comb begin
    ram_addr  = host_addr;
    ram_wdata = '0;
    ram_wen   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ram_addr  = load_addr;
        ram_wdata = 32'(char_data);
        ram_wen   = accept;
      end
      ST_FULL: ram_addr = load_addr;
`ifdef CHAR_BUFFER_CLEAR_EN
      ST_CLEAR: begin
        ram_addr = BASE + ADDR_W'(clr_q);
        ram_wen  = 1'b1;
      end
`endif
      ST_EXEC: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_wen   = cpu_wen;
      end
      default: ;
    endcase
  end

  assign char_count = count_q;
  assign buf_full   = full_q;
  assign overflow   = ovf_q;

endmodule
